fb_read_scaler: RTL and testbench



---
 rtl/fb_read_scaler.sv | 174 +++++++++++++++++
 tb/tb_fb_read_scaler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_read_scaler.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_scaler
// Description : Read-side address generator and pixel mux between the VGA
//               driver's next-pixel position and the dual-port frame buffer.
//               Places a SRC_W x SRC_H camera image at (x_off, y_off) on the
//               display, with optional 2x pixel/line replication, and drives
//               BORDER outside the image window.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          pixel clock, shared with frame buffer read port and VGA driver
//   rst          asynchronous active-high reset
//   scale2x      0 = 1x, 1 = 2x replication (latched at frame start)
//   x_off        window left edge in display pixels (latched at frame start)
//   y_off        window top edge in display lines (latched at frame start)
//   posX, posY   next-pixel position from the VGA driver
//   mem_addr     frame buffer read address (1 clk after posX/posY)
//   mem_data     frame buffer read data, valid 1 clk after mem_addr
//   pixel_out    pixel to the VGA driver (2 clk after posX/posY)
//   in_win       pixel_out carries image data, aligned with pixel_out
//   frame_start  one-clk pulse aligned with the pixel at posX=0, posY=0
// ============================================================================
module fb_read_scaler #(
    parameter int            SRC_W  = 320,
    parameter int            SRC_H  = 240,
    parameter int            AW     = 17,
    parameter int            DW     = 8,
    parameter int            DISP_W = 640,
    parameter int            DISP_H = 480,
    parameter logic [DW-1:0] BORDER = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scale2x,
    input  logic [9:0]    x_off,
    input  logic [8:0]    y_off,
    input  logic [9:0]    posX,
    input  logic [8:0]    posY,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          in_win,
    output logic          frame_start
);

    // Address used for every out-of-window pixel: first word past the image.
    localparam logic [AW-1:0] C_OOW_ADDR = AW'(SRC_W * SRC_H);
    localparam logic [AW-1:0] C_ROW_STEP = AW'(SRC_W);
    localparam logic [10:0]   C_WIN_W_1X = 11'(SRC_W);
    localparam logic [10:0]   C_WIN_W_2X = 11'(2 * SRC_W);
    localparam logic [10:0]   C_WIN_H_1X = 11'(SRC_H);
    localparam logic [10:0]   C_WIN_H_2X = 11'(2 * SRC_H);
    localparam logic [9:0]    C_DISP_W   = 10'(DISP_W);
    localparam logic [8:0]    C_DISP_H   = 9'(DISP_H);

    // Frame-latched configuration
    logic          scale_q,    scale_d;
    logic [9:0]    x_off_q,    x_off_d;
    logic [8:0]    y_off_q,    y_off_d;

    // Address accumulators
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] col_q,      col_d;

    // Pipeline registers
    logic [AW-1:0] mem_addr_q,    mem_addr_d;
    logic          win_d1_q,      win_d1_d;
    logic          fs_d1_q,       fs_d1_d;
    logic          in_win_q,      in_win_d;
    logic          frame_start_q, frame_start_d;

    // Stage-0 combinational terms
    logic          frame_pos;
    logic [10:0]   dx;
    logic [10:0]   dy;
    logic [10:0]   win_w;
    logic [10:0]   win_h;
    logic          h_in;
    logic          v_in;
    logic          win;

    always_comb begin
        frame_pos = (posX == 10'd0) && (posY == 9'd0);

        // The frame-start pixel itself already uses the new configuration,
        // so the whole frame (including its first pixel) sees one setting.
        scale_d = frame_pos ? scale2x : scale_q;
        x_off_d = frame_pos ? x_off   : x_off_q;
        y_off_d = frame_pos ? y_off   : y_off_q;

        // Zero-extended difference; bit 10 is the sign (posX < offset).
        dx = {1'b0, posX} - {1'b0, x_off_d};
        dy = {2'b00, posY} - {2'b00, y_off_d};

        win_w = scale_d ? C_WIN_W_2X : C_WIN_W_1X;
        win_h = scale_d ? C_WIN_H_2X : C_WIN_H_1X;

        h_in = !dx[10] && (dx < win_w) && (posX < C_DISP_W);
        v_in = !dy[10] && (dy < win_h) && (posY < C_DISP_H);
        win  = h_in && v_in;

        // Row base resynchronises at each line start (posX==0): cleared on
        // the first window line, stepped by one source row whenever dy>>s
        // advances. Lines are visited in order, so no pixel counting is
        // needed and blanking excursions of posX cannot disturb it.
        row_base_d = row_base_q;
        if (posX == 10'd0) begin
            if (dy == 11'd0) begin
                row_base_d = '0;
            end else if (!dy[10] && (dy < win_h) && (!scale_d || !dy[0])) begin
                row_base_d = row_base_q + C_ROW_STEP;
            end
        end

        // Column counter follows dx>>s: cleared at the window left edge and
        // advanced every pixel (1x) or on even dx (2x).
        col_d = col_q;
        if (h_in) begin
            if (dx == 11'd0) begin
                col_d = '0;
            end else if (!scale_d || !dx[0]) begin
                col_d = col_q + AW'(1);
            end
        end

        // Next-value bypass: posX==0 with x_off==0 needs this line's row base
        // and a cleared column in the same cycle.
        mem_addr_d    = win ? (row_base_d + col_d) : C_OOW_ADDR;
        win_d1_d      = win;
        fs_d1_d       = frame_pos;
        in_win_d      = win_d1_q;
        frame_start_d = fs_d1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q       <= 1'b0;
            x_off_q       <= '0;
            y_off_q       <= '0;
            row_base_q    <= '0;
            col_q         <= '0;
            mem_addr_q    <= C_OOW_ADDR;
            win_d1_q      <= 1'b0;
            fs_d1_q       <= 1'b0;
            in_win_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            scale_q       <= scale_d;
            x_off_q       <= x_off_d;
            y_off_q       <= y_off_d;
            row_base_q    <= row_base_d;
            col_q         <= col_d;
            mem_addr_q    <= mem_addr_d;
            win_d1_q      <= win_d1_d;
            fs_d1_q       <= fs_d1_d;
            in_win_q      <= in_win_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign in_win      = in_win_q;
    assign frame_start = frame_start_q;

    // The frame buffer's output register is the stage-2 data register: it
    // loads the word for mem_addr on the same edge that loads in_win_q, so
    // only the border substitution is applied here. Registering mem_data a
    // second time would put pixel_out one clock behind in_win. In reset
    // in_win_q is low, so pixel_out is BORDER immediately.
    assign pixel_out = in_win_q ? mem_data : BORDER;

endmodule
`default_nettype wire

// File: tb/tb_fb_read_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_read_scaler
// Description : Self-checking bench for fb_read_scaler. Drives raster frames
//               (randomly chosen full lines plus every line start) and checks
//               against an arithmetic reference of the window/address rules.
//               A synchronous-read frame buffer model supplies mem_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_read_scaler;

    localparam int SRC_W  = 320;
    localparam int SRC_H  = 240;
    localparam int AW     = 17;
    localparam int DW     = 8;
    localparam int DISP_W = 640;
    localparam int DISP_H = 480;
    localparam int OOW    = SRC_W * SRC_H;
    localparam int BORDER = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scale2x = 1'b0;
    logic [9:0]    x_off = '0;
    logic [8:0]    y_off = '0;
    logic [9:0]    posX = '0;
    logic [8:0]    posY = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] pixel_out;
    logic          in_win;
    logic          frame_start;

    fb_read_scaler #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .AW    (AW),
        .DW    (DW),
        .DISP_W(DISP_W),
        .DISP_H(DISP_H),
        .BORDER(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scale2x    (scale2x),
        .x_off      (x_off),
        .y_off      (y_off),
        .posX       (posX),
        .posY       (posY),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pixel_out  (pixel_out),
        .in_win     (in_win),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame buffer content: a simple address hash, nonzero at the reserved word.
    function automatic int hash(input int a);
        return (a * 37 + 11) & 255;
    endfunction

    // Synchronous-read frame buffer: data one clock after the address.
    always @(posedge clk) mem_data <= 8'(hash(int'(mem_addr)));

    int n_cmp = 0;
    int n_err = 0;
    int cur_x = 0;
    int cur_y = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s at posX=%0d posY=%0d: got %0d, expected %0d",
                     tag, cur_x, cur_y, obs, exp);
        end
    endtask

    // Reference: window and address straight from the placement rules.
    function automatic void ref_pix(input int x, input int y, input int s,
                                    input int xo, input int yo,
                                    output int addr, output bit win);
        int dx;
        int dy;
        dx   = x - xo;
        dy   = y - yo;
        win  = (dx >= 0) && (dx < (SRC_W << s)) && (dy >= 0) && (dy < (SRC_H << s))
               && (x < DISP_W) && (y < DISP_H);
        addr = win ? ((dy >> s) * SRC_W + (dx >> s)) : OOW;
    endfunction

    // Model state
    bit synced = 0;
    int lat_s  = 0;
    int lat_xo = 0;
    int lat_yo = 0;
    bit p_valid = 0;
    bit p_win   = 0;
    bit p_fs    = 0;
    int p_addr  = 0;
    int p_hit   = -1;
    int fs_seen = 0;

    // Directed probe points with hand-computed results
    int pr_x[$];
    int pr_y[$];
    int pr_a[$];
    bit pr_w[$];
    int pr_hit[$];
    int full_lines[$];

    task automatic add_probe(input int x, input int y, input int a, input bit w);
        pr_x.push_back(x);
        pr_y.push_back(y);
        pr_a.push_back(a);
        pr_w.push_back(w);
        pr_hit.push_back(0);
    endtask

    task automatic clear_probes();
        pr_x.delete();
        pr_y.delete();
        pr_a.delete();
        pr_w.delete();
        pr_hit.delete();
        p_hit = -1;
    endtask

    // One pixel clock: present (x,y), then check mem_addr for it and the
    // stage-2 outputs for the previous pixel.
    task automatic tick(input int x, input int y);
        int ea;
        bit ew;
        bit efs;
        int hit_idx;
        posX = x[9:0];
        posY = y[8:0];
        if (x == 0 && y == 0) begin
            lat_s  = scale2x ? 1 : 0;
            lat_xo = int'(x_off);
            lat_yo = int'(y_off);
            synced = 1;
        end
        ref_pix(x, y, lat_s, lat_xo, lat_yo, ea, ew);
        efs = (x == 0 && y == 0);
        hit_idx = -1;
        foreach (pr_x[i]) if (pr_x[i] == x && pr_y[i] == y) hit_idx = i;
        @(posedge clk);
        #1;
        cur_x = x;
        cur_y = y;
        if (synced) check("mem_addr", int'(mem_addr), ea);
        if (hit_idx >= 0) begin
            check("probe_addr", int'(mem_addr), pr_a[hit_idx]);
            pr_hit[hit_idx] = 1;
        end
        if (p_valid) begin
            check("in_win", int'(in_win), int'(p_win));
            check("pixel_out", int'(pixel_out), p_win ? hash(p_addr) : BORDER);
            check("frame_start", int'(frame_start), int'(p_fs));
        end
        if (p_hit >= 0) begin
            check("probe_in_win", int'(in_win), int'(pr_w[p_hit]));
            check("probe_pixel", int'(pixel_out), pr_w[p_hit] ? hash(pr_a[p_hit]) : BORDER);
        end
        fs_seen += int'(frame_start);
        p_valid = synced;
        p_win   = ew;
        p_addr  = ea;
        p_fs    = efs;
        p_hit   = hit_idx;
    endtask

    // Asynchronous reset in the middle of a line: outputs must drop at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_mem_addr", int'(mem_addr), OOW);
        check("rst_async_pixel_out", int'(pixel_out), BORDER);
        check("rst_async_in_win", int'(in_win), 0);
        check("rst_async_frame_start", int'(frame_start), 0);
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        synced  = 0;
        p_valid = 0;
        p_hit   = -1;
        lat_s   = 0;
        lat_xo  = 0;
        lat_yo  = 0;
    endtask

    // One raster frame. Every line gets its posX=0 start and a blanking
    // column; selected lines are swept across the whole active width.
    task automatic run_frame(input int s, input int xo, input int yo,
                             input int chg_y, input int chg_xo,
                             input int rst_y, input int pct);
        scale2x = s[0];
        x_off   = xo[9:0];
        y_off   = yo[8:0];
        fs_seen = 0;
        for (int y = 0; y < 490; y++) begin
            bit full;
            if (y == chg_y) x_off = chg_xo[9:0];
            full = ($urandom_range(99) < pct);
            foreach (full_lines[i]) if (full_lines[i] == y) full = 1;
            if (y == rst_y) begin
                for (int x = 0; x < 300; x++) tick(x, y);
                do_reset();
            end else if (full) begin
                for (int x = 0; x < DISP_W; x++) tick(x, y);
                tick(int'($urandom_range(799, 640)), y);
            end else begin
                tick(0, y);
                tick(int'($urandom_range(799, 640)), y);
            end
        end
        check("frame_start_per_frame", fs_seen, 1);
        foreach (pr_hit[i]) check("probe_reached", pr_hit[i], 1);
        clear_probes();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_addr", int'(mem_addr), OOW);
        check("reset_pixel_out", int'(pixel_out), BORDER);
        check("reset_in_win", int'(in_win), 0);
        check("reset_frame_start", int'(frame_start), 0);
        rst = 1'b0;

        // 1x, offsets 0
        full_lines = '{0, 3, 239};
        add_probe(5, 3, 965, 1);
        add_probe(319, 239, 76799, 1);
        add_probe(320, 0, OOW, 0);
        run_frame(0, 0, 0, -1, 0, -1, 1);

        // 2x, offsets 0: 2x2 replication over paired lines
        full_lines = '{4, 5, 478, 479};
        add_probe(7, 5, 643, 1);
        add_probe(639, 479, 76799, 1);
        run_frame(1, 0, 0, -1, 0, -1, 1);

        // 1x, centred window
        full_lines = '{120, 200, 359};
        add_probe(160, 120, 0, 1);
        add_probe(159, 120, OOW, 0);
        add_probe(480, 200, OOW, 0);
        add_probe(479, 359, 76799, 1);
        run_frame(0, 160, 120, -1, 0, -1, 1);

        // x_off changed mid-frame: no effect until next frame start
        full_lines = '{50, 60};
        add_probe(0, 60, 19200, 1);
        add_probe(99, 60, 19299, 1);
        run_frame(0, 0, 0, 50, 100, -1, 1);

        full_lines = '{0};
        add_probe(99, 0, OOW, 0);
        add_probe(100, 0, 0, 1);
        run_frame(0, 100, 0, -1, 0, -1, 1);

        // Reset at posY=200 with the image live, then a clean random frame
        full_lines = '{};
        run_frame(1, 40, 30, -1, 0, 200, 1);
        run_frame(int'($urandom_range(1)), int'($urandom_range(639)),
                  int'($urandom_range(479)), -1, 0, -1, 3);

        // 2x, clipped at right and bottom
        full_lines = '{100, 479};
        add_probe(199, 100, OOW, 0);
        add_probe(200, 100, 0, 1);
        add_probe(639, 479, 60699, 1);
        run_frame(1, 200, 100, -1, 0, -1, 1);

        // Random placement
        full_lines = '{};
        run_frame(int'($urandom_range(1)), int'($urandom_range(639)),
                  int'($urandom_range(479)), -1, 0, -1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
